// File: rtl/pc_sequencer_pkg.sv
// Shared defines for the fetch front end: next-PC opcodes, sequencer state
// encoding, the default reset PC and a small PC helper.
package pc_sequencer_pkg;

  // Next-PC unit opcodes (EX stage), kept beside the fetch encodings.
  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_JAL  = 3'd1;
  localparam logic [2:0] NPC_JALR = 3'd2;
  localparam logic [2:0] NPC_BR   = 3'd3;

  // Fetch sequencer state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Fetch address used after reset unless overridden.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding the PC of an instruction that was accepted
// from memory while decode was stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] pc
);

  // Clear wins over load so a redirect always empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer: issues fetch requests, advances the PC,
// parks a fetched instruction across load-use stalls, and squashes
// fetches on taken redirects from EX.
//
// Memory handshake: imem_req_o is a request held high (with a stable
// imem_addr_o) until the cycle imem_ack_i is seen; imem_ack_i completes the
// transfer in that cycle. An ack arriving when no live request exists
// (DROP, IDLE) belongs to an abandoned fetch and is discarded.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        load_use_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic        if_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic        stall_ifid_o,
  output logic        misalign_o,
  output logic [15:0] redirect_cnt_o,
  output logic [1:0]  state_dbg_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q;
  logic        misalign_q;
  logic        skid_load, skid_clear, skid_valid;
  logic [31:0] skid_pc;
  logic        in_fetch, in_hold;

  assign in_fetch = (state_q == ST_FETCH);
  assign in_hold  = (state_q == ST_HOLD);

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .load_pc (pc_q),
    .valid   (skid_valid),
    .pc      (skid_pc)
  );

  // Next state, next PC and skid control; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_i) begin
      pc_d       = align_pc(redirect_pc_i);
      skid_clear = 1'b1;
      // An unanswered request must still have its ack swallowed.
      if ((in_fetch || state_q == ST_DROP) && !imem_ack_i) state_d = ST_DROP;
      else                                                 state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (imem_ack_i) begin
            pc_d = pc_q + 32'd4;
            if (load_use_i) begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_DROP: if (imem_ack_i) state_d = ST_FETCH;
        default: begin
          if (!load_use_i) begin
            skid_clear = 1'b1;
            state_d    = ST_FETCH;
          end
        end
      endcase
    end
  end

  // State, PC, redirect counter and misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= 16'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

  // Outputs; combinational flush/stall are masked while reset is held.
  always_comb begin
    pc_o           = (in_hold && skid_valid) ? skid_pc : pc_q;
    pc4_o          = pc_o + 32'd4;
    imem_req_o     = in_fetch;
    imem_addr_o    = pc_q;
    flush_ifid_o   = redirect_i && rst_n;
    flush_idex_o   = redirect_i && rst_n;
    stall_ifid_o   = load_use_i && !redirect_i && rst_n;
    if_valid_o     = !redirect_i &&
                     ((in_fetch && imem_ack_i && !load_use_i) ||
                      (in_hold && skid_valid && !load_use_i));
    misalign_o     = misalign_q;
    redirect_cnt_o = cnt_q;
    state_dbg_o    = state_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected fetch PCs go into a queue as
// stimulus is issued, a monitor pops them whenever if_valid_o is seen.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        load_use_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic        if_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        flush_ifid_o;
  logic        flush_idex_o;
  logic        stall_ifid_o;
  logic        misalign_o;
  logic [15:0] redirect_cnt_o;
  logic [1:0]  state_dbg_o;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .load_use_i     (load_use_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .if_valid_o     (if_valid_o),
    .pc_o           (pc_o),
    .pc4_o          (pc4_o),
    .flush_ifid_o   (flush_ifid_o),
    .flush_idex_o   (flush_idex_o),
    .stall_ifid_o   (stall_ifid_o),
    .misalign_o     (misalign_o),
    .redirect_cnt_o (redirect_cnt_o),
    .state_dbg_o    (state_dbg_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive point just after the rising edge, sample point on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: every presented instruction must match the next expected PC.
  always @(negedge clk) begin
    if (if_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got pc %h expected no valid at %0t", pc_o, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc_o !== e) begin
          errors++;
          $display("FAIL valid_pc: got %h expected %h at %0t", pc_o, e, $time);
        end
      end
    end
  end

  initial begin
    // Reset with hostile inputs: flush/stall must stay low.
    rst_n = 1'b0; redirect_i = 1'b1; load_use_i = 1'b1;
    redirect_pc_i = 32'h0; imem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    samp();
    chk("rst_req", 32'(imem_req_o), 0);
    chk("rst_flush", 32'(flush_ifid_o | flush_idex_o), 0);
    chk("rst_stall", 32'(stall_ifid_o), 0);
    chk("rst_misalign", 32'(misalign_o), 0);
    chk("rst_cnt", 32'(redirect_cnt_o), 0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc4_o, 32'h4);
    tick();
    redirect_i = 1'b0; load_use_i = 1'b0; rst_n = 1'b1;
    samp(); chk("idle_req", 32'(imem_req_o), 0);
    tick();

    // Sequential fetch with ack every cycle.
    imem_ack_i = 1'b1; exp_q.push_back(32'h0);
    samp(); chk("f0_req", 32'(imem_req_o), 1); chk("f0_addr", imem_addr_o, 32'h0);
    tick();
    exp_q.push_back(32'h4);
    samp(); chk("f4_addr", imem_addr_o, 32'h4);
    tick();

    // Ack at pc 8 under load-use, hold one more stalled cycle, then release.
    load_use_i = 1'b1;
    samp(); chk("lu_addr", imem_addr_o, 32'h8); chk("lu_stall0", 32'(stall_ifid_o), 1);
    tick();
    imem_ack_i = 1'b0;
    samp(); chk("hold_stall", 32'(stall_ifid_o), 1); chk("hold_req", 32'(imem_req_o), 0);
    chk("hold_pc", pc_o, 32'h8);
    tick();
    load_use_i = 1'b0; exp_q.push_back(32'h8);
    samp(); chk("rel_pc", pc_o, 32'h8); chk("rel_stall", 32'(stall_ifid_o), 0);
    tick();
    for (int a = 12; a <= 28; a += 4) begin
      imem_ack_i = 1'b1; exp_q.push_back(32'(a));
      samp(); chk("seq_addr", imem_addr_o, 32'(a));
      tick();
    end

    // Request at 0x20 pending, redirect on the third cycle.
    imem_ack_i = 1'b0;
    repeat (2) begin
      samp(); chk("pend_addr", imem_addr_o, 32'h20); chk("pend_req", 32'(imem_req_o), 1);
      tick();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    samp(); chk("rd_flush_ifid", 32'(flush_ifid_o), 1); chk("rd_flush_idex", 32'(flush_idex_o), 1);
    tick();
    redirect_i = 1'b0;
    samp(); chk("drop_flush", 32'(flush_ifid_o), 0); chk("drop_req", 32'(imem_req_o), 0);
    tick();
    imem_ack_i = 1'b1;
    samp(); chk("drop_ack_req", 32'(imem_req_o), 0);
    tick();
    imem_ack_i = 1'b0;
    samp(); chk("new_req", 32'(imem_req_o), 1); chk("new_addr", imem_addr_o, 32'h100);
    chk("cnt1", 32'(redirect_cnt_o), 1); chk("aligned_no_pulse", 32'(misalign_o), 0);
    tick();

    // Redirect and load-use together, misaligned target.
    redirect_i = 1'b1; load_use_i = 1'b1; redirect_pc_i = 32'h202;
    samp(); chk("rl_flush", 32'(flush_ifid_o), 1); chk("rl_stall", 32'(stall_ifid_o), 0);
    tick();
    redirect_i = 1'b0; load_use_i = 1'b0;
    samp(); chk("misalign_pulse", 32'(misalign_o), 1); chk("rl_pc", pc_o, 32'h200);
    tick();
    imem_ack_i = 1'b1;
    samp(); chk("misalign_end", 32'(misalign_o), 0);
    tick();
    imem_ack_i = 1'b0;
    samp(); chk("a200_addr", imem_addr_o, 32'h200); chk("cnt2", 32'(redirect_cnt_o), 2);
    tick();

    // Redirect coincident with ack, then wrap at the top of the space.
    imem_ack_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    samp(); chk("co_flush", 32'(flush_ifid_o), 1);
    tick();
    redirect_i = 1'b0; exp_q.push_back(32'hFFFF_FFFC);
    samp(); chk("top_addr", imem_addr_o, 32'hFFFF_FFFC); chk("top_pc4", pc4_o, 32'h0);
    tick();
    imem_ack_i = 1'b0;
    samp(); chk("wrap_pc", pc_o, 32'h0); chk("wrap_req", 32'(imem_req_o), 1);
    chk("cnt3", 32'(redirect_cnt_o), 3);
    tick();

    // Long redirect burst: counter saturates.
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    repeat (65531) @(posedge clk);
    samp(); chk("cnt_fffe", 32'(redirect_cnt_o), 32'hFFFE);
    repeat (4469) @(posedge clk);
    #1 redirect_i = 1'b0;
    samp(); chk("cnt_sat", 32'(redirect_cnt_o), 32'hFFFF); chk("burst_drop_req", 32'(imem_req_o), 0);
    tick();

    // Reset in DROP with an ack arriving during and after reset.
    rst_n = 1'b0; imem_ack_i = 1'b1;
    samp(); chk("r2_req", 32'(imem_req_o), 0); chk("r2_cnt", 32'(redirect_cnt_o), 0);
    chk("r2_pc", pc_o, 32'h0);
    tick();
    rst_n = 1'b1;
    samp(); chk("r2_idle_req", 32'(imem_req_o), 0);
    tick();
    imem_ack_i = 1'b0;
    samp(); chk("r2_req_on", 32'(imem_req_o), 1); chk("r2_addr", imem_addr_o, 32'h0);
    tick();
    imem_ack_i = 1'b1; exp_q.push_back(32'h0);
    samp();
    tick();
    imem_ack_i = 1'b0;
    samp();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
